pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage RV32 core (IF/ID/EX/MEM/WB).
- Generates PC and pipeline-register load/flush controls.
- Handles load-use stalls and taken-branch/jump flushes resolved in MEM.
- Handles FENCE/ECALL halt with a drain sequence.
- Sits beside the forwarding unit; drives the existing Register load/rst-style controls.

Parameters:
DRAIN_CYCLES, 4, cycles spent draining older instructions before the HALTED state is entered (min 3).
CNT_W, 32, width of the optional performance counters.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
if_is_halt  in  1  IF-stage instruction is FENCE/ECALL/EBREAK
id_rs1  in  5  rs1 field of the instruction in ID
id_rs2  in  5  rs2 field of the instruction in ID
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  5  rd of the instruction in EX
mem_redirect  in  1  branch confirmed or jump in MEM (PC takes the MEM target)
pc_load  out  1  PC register load enable
if_id_load  out  1  IF/ID register load enable
if_id_flush  out  1  IF/ID loads a bubble (all-zero) this cycle
id_ex_flush  out  1  ID/EX loads a bubble this cycle
ex_mem_flush  out  1  EX/MEM loads a bubble this cycle
halted  out  1  core is halted
stall_cnt  out  CNT_W  load-use stall cycles (optional feature)
flush_cnt  out  CNT_W  redirect events (optional feature)

Behaviour:
- Clock/reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset state: state=RUN, drain counter=0, halted=0, counters=0.
- Reset output values: pc_load=1, if_id_load=1, all flushes=0.
- Control outputs are combinational from the registered state and current inputs (0-cycle latency). state, counter and halted are registered.
- Load-use hazard: lu = ex_mem_read && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2).
- State RUN, priority order:
  1. mem_redirect=1: pc_load=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1. lu and if_is_halt are ignored because those instructions are wrong-path. Stay in RUN.
  2. lu=1: pc_load=0, if_id_load=0, id_ex_flush=1 (one bubble). Stay in RUN. The halt check is deferred because IF is held and re-evaluated next cycle.
  3. if_is_halt=1: pc_load=0, if_id_flush=1. Go to DRAIN with counter=DRAIN_CYCLES-1.
  4. Otherwise: all loads=1, all flushes=0.
- State DRAIN:
  - pc_load=0 and if_id_flush=1 every cycle.
  - mem_redirect=1: the halt was speculative. Apply the full redirect flush with pc_load=1, then return to RUN and clear the counter.
  - lu=1 during DRAIN: id_ex_flush=1 and if_id_load=0 as in RUN. The counter still decrements.
  - counter==0 with no redirect: go to HALTED and set halted=1 on the next edge.
  - Otherwise decrement the counter.
- State HALTED: pc_load=0, if_id_load=0, if_id_flush=1, id_ex_flush=1, ex_mem_flush=0. halted=1. Exit only via rst.
- Reset mid-DRAIN or in HALTED: returns to RUN on the next cycle. No residual counter value.
- Simultaneous mem_redirect and lu in the same cycle: redirect wins. No stall is counted.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined: stall_cnt increments on each RUN/DRAIN cycle in which the lu stall is applied. flush_cnt increments on each cycle mem_redirect is acted on. Both wrap modulo 2^CNT_W, reset to 0, and freeze in HALTED.
- Undefined: both ports are tied to 0 and no counter flops are synthesized.

Decomposition:
- Package pipeline_ctrl_pkg:
  - state typedef {RUN, DRAIN, HALTED} (2-bit encoding);
  - REG_ZERO=5'd0;
  - default DRAIN_CYCLES constant;
  - halt opcode constants 7'b0001111 and 7'b1110011, shared with IF decode.
- One sub-module, load_use_detect: purely combinational lu computation, reusable by the forwarding unit testbench.

Test Plan:
- Reset release, no hazards: pc_load=1, if_id_load=1, all flushes 0, halted=0.
- ex_mem_read=1, ex_rd=5, id_rs2=5 for 1 cycle: pc_load=0, if_id_load=0, id_ex_flush=1. Next cycle with ex_mem_read=0: normal. stall_cnt=1 (with HAZARD_PERF_CNT_EN).
- Same as above but ex_rd=0: no stall.
- mem_redirect=1 with lu=1 and if_is_halt=1 in the same cycle: pc_load=1 and all three flushes=1, state stays RUN. flush_cnt=1, stall_cnt=0.
- if_is_halt=1 with no other inputs: pc_load=0 for 4 cycles of DRAIN, then halted=1 on the 5th edge. All loads stay 0 thereafter, even with if_is_halt=0.
- Halt, then mem_redirect=1 on the 2nd DRAIN cycle: redirect flush applied, back in RUN, halted never asserts. Asserting rst while in HALTED clears halted asynchronously.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: sequencer state type and constants shared by the hazard controller and IF decode.
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int DRAIN_CYCLES_DEF = 4;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the destination of a load still in EX.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rd,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  output logic       o_lu
);
  assign o_lu = i_ex_mem_read && (i_ex_rd != REG_ZERO) && (i_ex_rd == i_id_rs1 || i_ex_rd == i_id_rs2);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: PC/pipeline-register load and flush sequencing with load-use stall, MEM redirect and halt drain.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_is_halt,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_redirect,
  output logic             pc_load,
  output logic             if_id_load,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int DW = $clog2(DRAIN_CYCLES);
  state_t r_state, w_state_nxt;
  logic [DW-1:0] r_cnt, w_cnt_nxt;
  logic w_lu;
  load_use_detect u_lu (
    .i_ex_mem_read(ex_mem_read),
    .i_ex_rd(ex_rd),
    .i_id_rs1(id_rs1),
    .i_id_rs2(id_rs2),
    .o_lu(w_lu)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end
  // Redirect outranks everything outside HALTED: the stalled/halting instructions are wrong-path.
  always_comb begin
    pc_load = 1'b1;
    if_id_load = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_flush = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt = r_cnt;
    if (r_state == HALTED) begin
      pc_load = 1'b0;
      if_id_load = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (mem_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_flush = 1'b1;
      w_state_nxt = RUN;
      w_cnt_nxt = '0;
    end else begin
      if (w_lu) begin
        if_id_load = 1'b0;
        id_ex_flush = 1'b1;
      end
      if (r_state == DRAIN) begin
        pc_load = 1'b0;
        if_id_flush = 1'b1;
        w_state_nxt = (r_cnt == '0) ? HALTED : DRAIN;
        w_cnt_nxt = (r_cnt == '0) ? '0 : r_cnt - DW'(1);
      end else if (w_lu) begin
        pc_load = 1'b0;
      end else if (if_is_halt) begin
        pc_load = 1'b0;
        if_id_flush = 1'b1;
        w_state_nxt = DRAIN;
        w_cnt_nxt = DW'(DRAIN_CYCLES - 1);
      end
    end
  end
  assign halted = (r_state == HALTED);
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (r_state != HALTED) begin
      if (mem_redirect) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      else if (w_lu) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed + randomized checks of the hazard sequencer against a behavioural model.
module tb_pipeline_hazard_ctrl;
  localparam int DRAIN = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_is_halt = 1'b0, ex_mem_read = 1'b0, mem_redirect = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic pc_load, if_id_load, if_id_flush, id_ex_flush, ex_mem_flush, halted;
  logic [31:0] stall_cnt, flush_cnt;
  int n_chk = 0, n_err = 0;
  int m_left = -1;
  bit m_halt = 1'b0;
  logic [31:0] m_stalls = '0, m_flushes = '0;
  pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .if_is_halt(if_is_halt), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_redirect(mem_redirect),
    .pc_load(pc_load), .if_id_load(if_id_load), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] cnt_exp(input logic [31:0] v);
`ifdef HAZARD_PERF_CNT_EN
    return v;
`else
    return (v & 32'd0);
`endif
  endfunction
  // One clock: drive inputs while clk is low, compare against the model, then advance the model.
  task automatic step(input string tag, input bit h, input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit mr, input logic [4:0] rd, input bit redir);
    bit lu;
    logic [4:0] e;
    @(negedge clk);
    if_is_halt = h; id_rs1 = rs1; id_rs2 = rs2; ex_mem_read = mr; ex_rd = rd; mem_redirect = redir;
    #1;
    lu = mr && rd != 0 && (rd == rs1 || rd == rs2);
    chk({tag, ".halted"}, 32'(halted), 32'(m_halt));
    chk({tag, ".stall_cnt"}, stall_cnt, cnt_exp(m_stalls));
    chk({tag, ".flush_cnt"}, flush_cnt, cnt_exp(m_flushes));
    if (m_halt) e = 5'b00110;
    else if (redir) begin
      e = 5'b11111;
      m_flushes++;
      m_left = -1;
    end else if (m_left >= 0) begin
      e = {1'b0, !lu, 1'b1, lu, 1'b0};
      if (lu) m_stalls++;
      if (m_left == 0) m_halt = 1'b1;
      m_left--;
    end else if (lu) begin
      e = 5'b00010;
      m_stalls++;
    end else if (h) begin
      e = 5'b01100;
      m_left = DRAIN - 1;
    end else e = 5'b11000;
    chk({tag, ".ctrl"}, 32'({pc_load, if_id_load, if_id_flush, id_ex_flush, ex_mem_flush}), 32'(e));
  endtask
  task automatic async_reset(input string tag);
    @(negedge clk);
    if_is_halt = 0; ex_mem_read = 0; mem_redirect = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    #2 rst = 1'b1;
    #1;
    chk({tag, ".halted"}, 32'(halted), 32'd0);
    chk({tag, ".ctrl"}, 32'({pc_load, if_id_load, if_id_flush, id_ex_flush, ex_mem_flush}), 32'h18);
    chk({tag, ".stall_cnt"}, stall_cnt, 32'd0);
    chk({tag, ".flush_cnt"}, flush_cnt, 32'd0);
    #1 rst = 1'b0;
    m_left = -1; m_halt = 1'b0; m_stalls = '0; m_flushes = '0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    step("reset_idle", 0, 5'd1, 5'd2, 0, 5'd0, 0);
    step("lu_rs2", 0, 5'd3, 5'd5, 1, 5'd5, 0);
    step("lu_after", 0, 5'd3, 5'd5, 0, 5'd5, 0);
    chk("lu_stall_cnt", stall_cnt, cnt_exp(32'd1));
    step("lu_rd0", 0, 5'd0, 5'd0, 1, 5'd0, 0);
    step("lu_rs1", 0, 5'd7, 5'd9, 1, 5'd7, 0);
    async_reset("rst1");
    step("redir_lu_halt", 1, 5'd4, 5'd4, 1, 5'd4, 1);
    step("redir_after", 0, 5'd0, 5'd0, 0, 5'd0, 0);
    chk("redir_flush_cnt", flush_cnt, cnt_exp(32'd1));
    chk("redir_stall_cnt", stall_cnt, 32'd0);
    step("halt_go", 1, 5'd0, 5'd0, 0, 5'd0, 0);
    for (int i = 0; i < DRAIN; i++) step("drain", 0, 5'd0, 5'd0, 0, 5'd0, 0);
    step("halted_idle", 0, 5'd0, 5'd0, 0, 5'd0, 0);
    chk("halted_direct", 32'(halted), 32'd1);
    step("halted_redir", 0, 5'd2, 5'd2, 1, 5'd2, 1);
    async_reset("rst_halted");
    step("halt_go2", 1, 5'd0, 5'd0, 0, 5'd0, 0);
    step("drain2_1", 0, 5'd0, 5'd0, 0, 5'd0, 0);
    step("drain2_redir", 0, 5'd0, 5'd0, 0, 5'd0, 1);
    for (int i = 0; i < 6; i++) step("post_redir", 0, 5'd0, 5'd0, 0, 5'd0, 0);
    step("halt_go3", 1, 5'd0, 5'd0, 0, 5'd0, 0);
    step("drain3_lu", 0, 5'd6, 5'd1, 1, 5'd6, 0);
    step("drain3_2", 0, 5'd0, 5'd0, 0, 5'd0, 0);
    async_reset("rst_drain");
    step("after_rst_drain", 0, 5'd0, 5'd0, 0, 5'd0, 0);
    for (int i = 0; i < 3000; i++) begin
      if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) async_reset("rand_rst");
      else step("rand", $urandom_range(0, 7) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom_range(0, 5) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
